// File: rtl/agc_io_pkg.sv
// Shared types and constants for the AGC I/O channel block.
// Channel 7 is a status word and not a stored channel.
package agc_io_pkg;

  typedef logic [14:0] word_t;
  typedef logic [2:0]  chan_t;

  localparam chan_t STATUS_CHAN  = 3'd7;
  localparam int    STAT_OVF_BIT = 14;
  localparam int    STAT_CNT_LSB = 7;
  localparam int    STAT_UPD_MSB = 6;

  typedef struct packed {
    chan_t chan;
    word_t data;
  } fifo_entry_t;

endpackage

// File: rtl/agc_io_fifo.sv
// Show-ahead FIFO for outbound channel writes.
// Push-when-full is dropped here; the parent flags it.
module agc_io_fifo
  import agc_io_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  fifo_entry_t entry_i,
  input  logic        pop_i,
  output fifo_entry_t head_o,
  output logic        empty_o,
  output logic        full_o,
  output logic [4:0]  count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t         mem_q [DEPTH];
  logic [AW-1:0]       wr_q, wr_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                do_push, do_pop;

  assign empty_o = (cnt_q == 5'd0);
  assign full_o  = (cnt_q == 5'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // A pop frees the slot, so push into a full FIFO is fine then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= entry_i;
    end
  end

endmodule

// File: rtl/agc_io_channel_unit.sv
// AGC memory-mapped I/O channel block: 7 channels + status on ch7.
// Optional io_irq output when AGC_IO_IRQ_EN is defined.
module agc_io_channel_unit
  import agc_io_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] OUT_MASK   = 8'h0F,
  parameter logic [7:0] IN_MASK    = 8'h70
) (
  input  logic  clock,
  input  logic  reset_n,
  input  chan_t IO_read_sel,
  output word_t IO_read_data,
  input  chan_t IO_write_sel,
  input  word_t IO_write_data,
  input  logic  IO_write_en,
  output logic  out_valid,
  input  logic  out_ready,
  output chan_t out_chan,
  output word_t out_data,
  input  logic  in_valid,
  output logic  in_ready,
  input  chan_t in_chan,
  input  word_t in_data
`ifdef AGC_IO_IRQ_EN
  ,
  output logic  io_irq
`endif
);

  word_t       chan_q [7];
  word_t       chan_d [7];
  word_t       rd_q, rd_d;
  logic [6:0]  upd_q, upd_d;
  logic        ovf_q, ovf_d;
  logic        wr_core, push, pop, in_take;
  logic        fifo_empty, fifo_full;
  logic [4:0]  fifo_cnt;
  fifo_entry_t head, entry;
  word_t       status;

  assign wr_core = IO_write_en && (IO_write_sel != STATUS_CHAN);
  assign push    = wr_core && OUT_MASK[IO_write_sel];
  assign pop     = out_valid && out_ready;
  assign entry   = '{chan: IO_write_sel, data: IO_write_data};

  // Core wins a same-channel collision by stalling the port.
  assign in_ready = reset_n &&
    !(IO_write_en && (IO_write_sel == in_chan));
  assign in_take  = in_valid && in_ready &&
    IN_MASK[in_chan] && (in_chan != STATUS_CHAN);

  assign status = {ovf_q, 2'b00, fifo_cnt, upd_q};

  agc_io_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .push_i  (push),
    .entry_i (entry),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  assign out_valid    = !fifo_empty;
  assign out_chan     = head.chan;
  assign out_data     = head.data;
  assign IO_read_data = rd_q;

  always_comb begin
    rd_d  = status;
    upd_d = upd_q;
    ovf_d = ovf_q;
    for (int i = 0; i < 7; i++) begin
      chan_d[i] = chan_q[i];
      if (IO_read_sel == 3'(i)) rd_d = chan_q[i];
    end
    if (IO_read_sel == STATUS_CHAN) upd_d = '0;
    for (int i = 0; i < 7; i++) begin
      if (wr_core && IO_write_sel == 3'(i)) begin
        chan_d[i] = IO_write_data;
      end else if (in_take && in_chan == 3'(i)) begin
        chan_d[i] = in_data;
        upd_d[i]  = 1'b1;
      end
    end
    if (IO_write_en && IO_write_sel == STATUS_CHAN &&
        IO_write_data[STAT_OVF_BIT]) ovf_d = 1'b0;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_q  <= '0;
      upd_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < 7; i++) chan_q[i] <= '0;
    end else begin
      rd_q  <= rd_d;
      upd_q <= upd_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < 7; i++) chan_q[i] <= chan_d[i];
    end
  end

`ifdef AGC_IO_IRQ_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) io_irq <= 1'b0;
    else          io_irq <= |upd_d;
  end
`endif

endmodule
